// File: rtl/fetch_pkg.sv
// Shared definitions for the Kestrel-2 instruction fetch unit:
// FSM state encodings, FIFO entry layout and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // Word address fetched first after reset.
    localparam logic [15:1] RESET_PC_DEF = 15'h0000;

    // FIFO entry: {word address [15:1], instruction [15:0]}.
    localparam int ENTRY_W = 31;

    // Sequential next word address; wraps 15'h7FFF -> 15'h0000.
    function automatic logic [15:1] next_word(input logic [15:1] adr);
        return adr + 15'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH x W entries, registered storage, head visible
// combinationally from the storage array. Flush empties the FIFO and
// overrides any push/pop on the same edge.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 31,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic [W-1:0]  head_o
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i & ~flush_i & (count_q != FULL);
    assign do_pop  = pop_i  & ~flush_i & (count_q != '0);

    // Storage, pointers and occupancy; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/ins_fetch.sv
// Kestrel-2 instruction fetch: Wishbone read initiator feeding a prefetch
// FIFO towards the decoder. Branch redirects flush the FIFO; a bus cycle
// already in flight is allowed to finish and its data is dropped.
// Optional feature macro: FETCH_TIMEOUT_EN (ACK timeout with sticky
// fetch_err_o and retry of the same address).
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | no bus cycle; start one when the FIFO has room
//   S_BUS   | CYC/STB high, waiting for ACK of a wanted fetch
//   S_DRAIN | CYC/STB high, waiting for ACK of a cycle to be discarded
module ins_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:1] RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = 15
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    output logic [15:1] ins_adr_o,
    input  logic [15:0] ins_dat_i,
    output logic        ins_cyc_o,
    output logic        ins_stb_o,
    input  logic        ins_ack_i,
    input  logic        redirect_i,
    input  logic [15:1] redirect_adr_i,
    output logic [15:0] insn_o,
    output logic [15:1] insn_pc_o,
    output logic        insn_valid_o,
    input  logic        insn_ready_i,
    output logic        fetch_err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic [15:1]  ptr_q, ptr_d;
    logic [15:1]  adr_q, adr_d;

    logic               in_cycle;
    logic               ack;
    logic               tmo_hit;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               room_after;

    assign in_cycle = (state_q != S_IDLE);
    assign ack      = ins_ack_i & in_cycle;

    assign ins_cyc_o = in_cycle;
    assign ins_stb_o = in_cycle;
    assign ins_adr_o = adr_q;

    assign insn_valid_o = (fifo_count != '0);
    assign insn_pc_o    = fifo_head[30:16];
    assign insn_o       = fifo_head[15:0];

    // A redirect discards whatever is being handed over this cycle.
    assign fifo_pop   = insn_valid_o & insn_ready_i & ~redirect_i;
    assign fifo_flush = redirect_i;

    // Occupancy after this edge's push (+1) and pop is still below DEPTH.
    assign room_after = fifo_pop | (fifo_count < FULL_M1);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i   (sys_clk_i),
        .rst_n_i (sys_rst_n_i),
        .push_i  (fifo_push),
        .data_i  ({adr_q, ins_dat_i}),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    // Next-state, fetch pointer and bus address selection.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        adr_d     = adr_q;
        fifo_push = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    ptr_d   = redirect_adr_i;
                    adr_d   = redirect_adr_i;
                    state_d = S_BUS;
                end else if (fifo_count != FULL) begin
                    adr_d   = ptr_q;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (redirect_i) begin
                    ptr_d = redirect_adr_i;
                    if (ack) begin
                        adr_d = redirect_adr_i;
                    end else if (tmo_hit) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (ack) begin
                    fifo_push = 1'b1;
                    ptr_d     = next_word(ptr_q);
                    if (room_after) begin
                        adr_d = next_word(ptr_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (redirect_i) begin
                    ptr_d = redirect_adr_i;
                end
                if (ack) begin
                    adr_d   = redirect_i ? redirect_adr_i : ptr_q;
                    state_d = S_BUS;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, pointer and address registers.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q <= S_IDLE;
            ptr_q   <= RESET_PC;
            adr_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            adr_q   <= adr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q;

    // The cycle is abandoned on the edge that completes TIMEOUT clocks
    // of CYC without ACK.
    assign tmo_hit = in_cycle & ~ack & (tmo_q == TMO_W'(TIMEOUT - 1));

    // Wait counter: runs only while a cycle is open and no ACK arrives.
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (!in_cycle || ack || tmo_hit) begin
            tmo_d = '0;
        end
    end

    // Counter and sticky error flag.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_q | tmo_hit;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    // Always 0 here; TIMEOUT only matters when the timeout is built in.
    assign fetch_err_o = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch against a one-wait-state Wishbone responder
// returning data = {1'b0, address} ^ 16'hA5A5.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:1] ins_adr;
    logic [15:0] ins_dat;
    logic        ins_cyc;
    logic        ins_stb;
    logic        ins_ack;
    logic        redirect = 1'b0;
    logic [15:1] redirect_adr = '0;
    logic [15:0] insn;
    logic [15:1] insn_pc;
    logic        insn_valid;
    logic        insn_ready = 1'b1;
    logic        fetch_err;
    logic        ack_en = 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ins_fetch #(
        .DEPTH    (2),
        .RESET_PC (15'h0000),
        .TIMEOUT  (15)
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_n_i    (rst_n),
        .ins_adr_o      (ins_adr),
        .ins_dat_i      (ins_dat),
        .ins_cyc_o      (ins_cyc),
        .ins_stb_o      (ins_stb),
        .ins_ack_i      (ins_ack),
        .redirect_i     (redirect),
        .redirect_adr_i (redirect_adr),
        .insn_o         (insn),
        .insn_pc_o      (insn_pc),
        .insn_valid_o   (insn_valid),
        .insn_ready_i   (insn_ready),
        .fetch_err_o    (fetch_err)
    );

    // One-wait-state responder: registered ACK, one pulse per request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ins_ack <= 1'b0;
        else        ins_ack <= ins_cyc & ins_stb & ~ins_ack & ack_en;
    end
    assign ins_dat = ins_ack ? ({1'b0, ins_adr} ^ 16'hA5A5) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset held over two falling edges; next rising edge is "edge 0".
    task automatic do_reset();
        rst_n        = 1'b0;
        redirect     = 1'b0;
        redirect_adr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_cyc",   32'(ins_cyc),    32'h0);
        chk("rst_stb",   32'(ins_stb),    32'h0);
        chk("rst_adr",   32'(ins_adr),    32'h0);
        chk("rst_valid", 32'(insn_valid), 32'h0);
        chk("rst_insn",  32'(insn),       32'h0);
        chk("rst_pc",    32'(insn_pc),    32'h0);
        chk("rst_err",   32'(fetch_err),  32'h0);

        // Streaming with ready=1: words 0,1,2 valid after edges 2,4,6
        insn_ready = 1'b1;
        ack_en     = 1'b1;
        do_reset();
        tick(1);
        chk("e0_stb",   32'(ins_stb), 32'h1);
        chk("e0_adr",   32'(ins_adr), 32'h0);
        tick(1);
        chk("e1_valid", 32'(insn_valid), 32'h0);
        tick(1);
        chk("e2_valid", 32'(insn_valid), 32'h1);
        chk("e2_insn",  32'(insn),       32'hA5A5);
        chk("e2_pc",    32'(insn_pc),    32'h0000);
        chk("e2_adr",   32'(ins_adr),    32'h0001);
        tick(1);
        chk("e3_valid", 32'(insn_valid), 32'h0);
        chk("e3_stb",   32'(ins_stb),    32'h1);
        tick(1);
        chk("e4_valid", 32'(insn_valid), 32'h1);
        chk("e4_insn",  32'(insn),       32'hA5A4);
        chk("e4_pc",    32'(insn_pc),    32'h0001);
        chk("e4_stb",   32'(ins_stb),    32'h1);
        tick(2);
        chk("e6_valid", 32'(insn_valid), 32'h1);
        chk("e6_insn",  32'(insn),       32'hA5A7);
        chk("e6_pc",    32'(insn_pc),    32'h0002);

        // Asynchronous reset mid-cycle drops CYC/STB without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(ins_cyc), 32'h0);
        chk("arst_stb", 32'(ins_stb), 32'h0);

        // Back-pressure: DEPTH=2 -> two bus cycles then idle
        insn_ready = 1'b0;
        do_reset();
        tick(5);
        chk("bp_e4_cyc",   32'(ins_cyc),    32'h0);
        chk("bp_e4_valid", 32'(insn_valid), 32'h1);
        chk("bp_e4_pc",    32'(insn_pc),    32'h0000);
        chk("bp_e4_insn",  32'(insn),       32'hA5A5);
        tick(4);
        chk("bp_e8_cyc",   32'(ins_cyc),    32'h0);
        insn_ready = 1'b1;
        tick(1);
        insn_ready = 1'b0;
        chk("bp_e9_pc",    32'(insn_pc),    32'h0001);
        chk("bp_e9_insn",  32'(insn),       32'hA5A4);
        tick(1);
        chk("bp_e10_cyc",  32'(ins_cyc),    32'h1);
        chk("bp_e10_adr",  32'(ins_adr),    32'h0002);
        tick(2);
        chk("bp_e12_cyc",  32'(ins_cyc),    32'h0);
        chk("bp_e12_pc",   32'(insn_pc),    32'h0001);

        // Redirect while waiting for ACK: cycle drains, data discarded
        insn_ready = 1'b1;
        do_reset();
        tick(1);
        redirect     = 1'b1;
        redirect_adr = 15'h1234;
        tick(1);
        redirect = 1'b0;
        chk("rd_e1_cyc",   32'(ins_cyc),    32'h1);
        chk("rd_e1_adr",   32'(ins_adr),    32'h0000);
        tick(1);
        chk("rd_e2_valid", 32'(insn_valid), 32'h0);
        chk("rd_e2_adr",   32'(ins_adr),    32'h1234);
        tick(2);
        chk("rd_e4_valid", 32'(insn_valid), 32'h1);
        chk("rd_e4_pc",    32'(insn_pc),    32'h1234);
        chk("rd_e4_insn",  32'(insn),       32'hB791);
        chk("rd_e4_adr",   32'(ins_adr),    32'h1235);

        // Redirect + pop on the same edge as ACK: FIFO empty, data dropped
        insn_ready = 1'b0;
        tick(1);
        insn_ready   = 1'b1;
        redirect     = 1'b1;
        redirect_adr = 15'h0100;
        tick(1);
        redirect = 1'b0;
        chk("rpa_valid",   32'(insn_valid), 32'h0);
        chk("rpa_adr",     32'(ins_adr),    32'h0100);
        tick(2);
        chk("rpa_e8_valid", 32'(insn_valid), 32'h1);
        chk("rpa_e8_pc",    32'(insn_pc),    32'h0100);
        chk("rpa_e8_insn",  32'(insn),       32'hA4A5);

        // Redirect from IDLE to 15'h7FFF, then pointer wraps to 0
        do_reset();
        redirect     = 1'b1;
        redirect_adr = 15'h7FFF;
        tick(1);
        redirect = 1'b0;
        chk("wr_e0_adr",  32'(ins_adr),  32'h7FFF);
        tick(2);
        chk("wr_e2_pc",   32'(insn_pc),  32'h7FFF);
        chk("wr_e2_insn", 32'(insn),     32'hDA5A);
        chk("wr_e2_adr",  32'(ins_adr),  32'h0000);
        tick(2);
        chk("wr_e4_pc",   32'(insn_pc),  32'h0000);
        chk("wr_e4_insn", 32'(insn),     32'hA5A5);

        // Responder never acks
        ack_en = 1'b0;
        do_reset();
        redirect     = 1'b1;
        redirect_adr = 15'h0042;
        tick(1);
        redirect = 1'b0;
        chk("to_e0_adr", 32'(ins_adr), 32'h0042);
`ifdef FETCH_TIMEOUT_EN
        tick(14);
        chk("to_e14_cyc", 32'(ins_cyc),   32'h1);
        chk("to_e14_err", 32'(fetch_err), 32'h0);
        tick(1);
        chk("to_e15_cyc", 32'(ins_cyc),   32'h0);
        chk("to_e15_err", 32'(fetch_err), 32'h1);
        tick(1);
        chk("to_e16_cyc", 32'(ins_cyc),   32'h1);
        chk("to_e16_adr", 32'(ins_adr),   32'h0042);
        chk("to_e16_err", 32'(fetch_err), 32'h1);
`else
        tick(40);
        chk("nto_cyc", 32'(ins_cyc),   32'h1);
        chk("nto_adr", 32'(ins_adr),   32'h0042);
        chk("nto_err", 32'(fetch_err), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
